// File: rtl/axi_sub_pkg.sv
// -----------------------------------------------------------------------------
// axi_sub_pkg
//   Shared definitions for the AXI4-Lite register subordinate:
//     - AXI response codes (OKAY / SLVERR)
//     - VERSION_VAL, the constant returned by the optional read-only
//       version register (enabled with the AXI_SUB_VERSION_REG_EN macro)
//     - state enums for the write and read handshake FSMs
//     - resp_code(): maps an error flag onto the AXI response encoding
// -----------------------------------------------------------------------------
package axi_sub_pkg;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    localparam logic [31:0] VERSION_VAL = 32'h0001_0000;

    // Write FSM: collect AW and W (any order), then hold the B response.
    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } w_state_e;

    // Read FSM: accept AR, then hold the R beat until the manager takes it.
    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

    function automatic logic [1:0] resp_code(input logic err);
        return err ? RESP_SLVERR : RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_sub_regfile.sv
// -----------------------------------------------------------------------------
// axi_sub_regfile
//   Bank of NUM_REGS word registers with one synchronous write port and one
//   asynchronous (combinational) read port. A write and a read of the same
//   index in the same cycle return the old value on the read port, since
//   the array only updates on the clock edge.
//
//   Ports:
//     clk       in   clock, rising edge
//     resetn    in   asynchronous active-low reset, clears every register
//     we_i      in   write enable
//     widx_i    in   write index
//     wdata_i   in   write data
//     ridx_i    in   read index
//     rdata_o   out  read data (combinational from ridx_i)
// -----------------------------------------------------------------------------
module axi_sub_regfile #(
    parameter int NUM_REGS = 16,
    parameter int DATA_W   = 32,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  widx_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]  ridx_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[widx_i] <= wdata_i;
        end
    end

    assign rdata_o = regs_q[ridx_i];

endmodule

// File: rtl/axi_lite_sub_regs.sv
// -----------------------------------------------------------------------------
// axi_lite_sub_regs
//   AXI4-Lite subordinate exposing NUM_REGS read/write 32-bit registers at
//   byte addresses 0x00 .. NUM_REGS*4-4. One read and one write may be in
//   flight at a time; the two channels are fully independent. Unmapped
//   addresses are answered with SLVERR (reads return zero data, writes are
//   dropped).
//
//   Optional feature (macro AXI_SUB_VERSION_REG_EN):
//     defined   -> the last register (index NUM_REGS-1) reads VERSION_VAL
//                  and rejects writes with SLVERR
//     undefined -> the last register is an ordinary read/write register
//
//   Handshake rule for every channel: a transfer happens on the rising edge
//   where valid and ready are both 1. A subordinate-driven valid (bvalid,
//   rvalid) is held, with its payload unchanged, until the matching ready is
//   seen high on an edge. All ready/valid/payload outputs come straight from
//   flops.
//
//   Ports (all sampled on rising clk, resetn asynchronous active-low):
//     s_axi_aw*  write address channel  (awaddr, awvalid in; awready out)
//     s_axi_w*   write data channel     (wdata, wvalid in; wready out)
//     s_axi_b*   write response channel (bresp, bvalid out; bready in)
//     s_axi_ar*  read address channel   (araddr, arvalid in; arready out)
//     s_axi_r*   read data channel      (rdata, rresp, rvalid out; rready in)
// -----------------------------------------------------------------------------
module axi_lite_sub_regs
    import axi_sub_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,

    input  logic [DATA_W-1:0] s_axi_wdata,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,

    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,

    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,

    output logic [DATA_W-1:0] s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready
);

    localparam int                IDX_W       = $clog2(NUM_REGS);
    localparam logic [ADDR_W-1:0] MAP_LIMIT   = ADDR_W'(NUM_REGS * 4);
    localparam logic [IDX_W-1:0]  VERSION_IDX = IDX_W'(NUM_REGS - 1);

`ifdef AXI_SUB_VERSION_REG_EN
    localparam logic VERSION_EN = 1'b1;
`else
    localparam logic VERSION_EN = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Write path state
    // -------------------------------------------------------------------------
    w_state_e          w_state_q, w_state_d;
    logic              aw_done_q, aw_done_d;   // AW captured, waiting for W
    logic              w_done_q,  w_done_d;    // W captured, waiting for AW
    logic [ADDR_W-1:0] awaddr_q,  awaddr_d;
    logic [DATA_W-1:0] wdata_q,   wdata_d;
    logic              awready_q, awready_d;
    logic              wready_q,  wready_d;
    logic              bvalid_q,  bvalid_d;
    logic [1:0]        bresp_q,   bresp_d;

    logic              aw_hs;
    logic              w_hs;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [IDX_W-1:0]  wr_idx;
    logic              wr_mapped;
    logic              wr_ok;
    logic              wr_fire;
    logic              rf_we;

    // -------------------------------------------------------------------------
    // Read path state
    // -------------------------------------------------------------------------
    r_state_e          r_state_q, r_state_d;
    logic              arready_q, arready_d;
    logic              rvalid_q,  rvalid_d;
    logic [DATA_W-1:0] rdata_q,   rdata_d;
    logic [1:0]        rresp_q,   rresp_d;

    logic              ar_hs;
    logic [IDX_W-1:0]  rd_idx;
    logic              rd_mapped;
    logic              rd_version;
    logic [DATA_W-1:0] rf_rdata;

    // -------------------------------------------------------------------------
    // Write decode
    // -------------------------------------------------------------------------
    assign aw_hs = s_axi_awvalid && awready_q;
    assign w_hs  = s_axi_wvalid  && wready_q;

    // A channel handshaking this cycle supplies its payload directly, so a
    // write can complete in the same cycle as the later of AW and W.
    assign wr_addr   = aw_hs ? s_axi_awaddr : awaddr_q;
    assign wr_data   = w_hs  ? s_axi_wdata  : wdata_q;
    assign wr_idx    = wr_addr[IDX_W+1:2];
    assign wr_mapped = (wr_addr < MAP_LIMIT);
    assign wr_ok     = wr_mapped && !(VERSION_EN && (wr_idx == VERSION_IDX));
    assign wr_fire   = (w_state_q == W_IDLE) &&
                       (aw_done_q || aw_hs) && (w_done_q || w_hs);
    assign rf_we     = wr_fire && wr_ok;

    // -------------------------------------------------------------------------
    // Read decode
    // -------------------------------------------------------------------------
    assign ar_hs      = s_axi_arvalid && arready_q;
    assign rd_idx     = s_axi_araddr[IDX_W+1:2];
    assign rd_mapped  = (s_axi_araddr < MAP_LIMIT);
    assign rd_version = VERSION_EN && (rd_idx == VERSION_IDX);

    // -------------------------------------------------------------------------
    // Register array
    // -------------------------------------------------------------------------
    axi_sub_regfile #(
        .NUM_REGS (NUM_REGS),
        .DATA_W   (DATA_W),
        .IDX_W    (IDX_W)
    ) u_regfile (
        .clk     (clk),
        .resetn  (resetn),
        .we_i    (rf_we),
        .widx_i  (wr_idx),
        .wdata_i (wr_data),
        .ridx_i  (rd_idx),
        .rdata_o (rf_rdata)
    );

    // -------------------------------------------------------------------------
    // Write FSM: state and registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            w_state_q <= W_IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            w_state_q <= w_state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

    // Write FSM: next state
    always_comb begin
        w_state_d = w_state_q;
        unique case (w_state_q)
            W_IDLE: if (wr_fire)                    w_state_d = W_RESP;
            W_RESP: if (bvalid_q && s_axi_bready)   w_state_d = W_IDLE;
        endcase
    end

    // Write FSM: output / datapath next values
    always_comb begin
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        unique case (w_state_q)
            W_IDLE: begin
                if (wr_fire) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                    bvalid_d  = 1'b1;
                    bresp_d   = resp_code(!wr_ok);
                end else begin
                    if (aw_hs) begin
                        aw_done_d = 1'b1;
                        awaddr_d  = s_axi_awaddr;
                    end
                    if (w_hs) begin
                        w_done_d = 1'b1;
                        wdata_d  = s_axi_wdata;
                    end
                    // Also raises the readies on the first cycle after reset.
                    awready_d = !(aw_done_q || aw_hs);
                    wready_d  = !(w_done_q  || w_hs);
                end
            end
            W_RESP: begin
                if (bvalid_q && s_axi_bready) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                end
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Read FSM: state and registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    // Read FSM: next state
    always_comb begin
        r_state_d = r_state_q;
        unique case (r_state_q)
            R_IDLE: if (ar_hs)        r_state_d = R_DATA;
            R_DATA: if (s_axi_rready) r_state_d = R_IDLE;
        endcase
    end

    // Read FSM: output next values
    always_comb begin
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        unique case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rresp_d   = resp_code(!rd_mapped);
                    if (!rd_mapped) begin
                        rdata_d = '0;
                    end else if (rd_version) begin
                        rdata_d = DATA_W'(VERSION_VAL);
                    end else begin
                        rdata_d = rf_rdata;
                    end
                end else begin
                    arready_d = 1'b1;
                end
            end
            R_DATA: begin
                if (s_axi_rready) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                end
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Port assignments
    // -------------------------------------------------------------------------
    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;

endmodule

// File: tb/tb_axi_lite_sub_regs.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_sub_regs
//   Self-checking bench for axi_lite_sub_regs. A word-array model of the
//   register map predicts every B and R response; drivers push predictions
//   into expected queues and a single negedge monitor compares the DUT
//   against the queue heads, and checks hold-while-stalled behaviour.
// -----------------------------------------------------------------------------
module tb_axi_lite_sub_regs;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 16;
    localparam int TMO      = 64;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

`ifdef AXI_SUB_VERSION_REG_EN
    localparam bit VER_EN = 1'b1;
`else
    localparam bit VER_EN = 1'b0;
`endif

    // ---------------------------------------------------------------- signals
    logic              clk;
    logic              resetn;
    logic [ADDR_W-1:0] s_axi_awaddr;
    logic              s_axi_awvalid;
    logic              s_axi_awready;
    logic [DATA_W-1:0] s_axi_wdata;
    logic              s_axi_wvalid;
    logic              s_axi_wready;
    logic [1:0]        s_axi_bresp;
    logic              s_axi_bvalid;
    logic              s_axi_bready;
    logic [ADDR_W-1:0] s_axi_araddr;
    logic              s_axi_arvalid;
    logic              s_axi_arready;
    logic [DATA_W-1:0] s_axi_rdata;
    logic [1:0]        s_axi_rresp;
    logic              s_axi_rvalid;
    logic              s_axi_rready;

    axi_lite_sub_regs #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready)
    );

    // ------------------------------------------------------ clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------ scoreboard
    int total = 0;
    int bad   = 0;

    logic [DATA_W-1:0] model [NUM_REGS];
    logic [1:0]        exp_b_q[$];
    logic [33:0]       exp_r_q[$];   // {rresp, rdata}

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: event missing or unexpected at %0t", name, $time);
    endtask

    // ------------------------------------------------------ reference model
    function automatic bit addr_mapped(input logic [31:0] a);
        return a < 32'(NUM_REGS * 4);
    endfunction

    function automatic int addr_idx(input logic [31:0] a);
        return int'(a >> 2);
    endfunction

    function automatic bit is_version(input logic [31:0] a);
        return VER_EN && addr_mapped(a) && (addr_idx(a) == NUM_REGS - 1);
    endfunction

    function automatic logic [1:0] model_wresp(input logic [31:0] a);
        if (!addr_mapped(a) || is_version(a)) return SLVERR;
        return OKAY;
    endfunction

    function automatic logic [33:0] model_read(input logic [31:0] a);
        if (!addr_mapped(a)) return {SLVERR, 32'h0};
        if (is_version(a))   return {OKAY, 32'h0001_0000};
        return {OKAY, model[addr_idx(a)]};
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d);
        if (model_wresp(a) == OKAY) model[addr_idx(a)] = d;
    endtask

    task automatic model_clear();
        for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
    endtask

    // ------------------------------------------------------ drivers
    // All drivers are entered and left at posedge+1.
    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_drv(input logic [31:0] a, input logic [31:0] d,
                             input int aw_dly, input int w_dly, input int b_dly);
        fork
            begin
                bit hs;
                int n;
                wait_cycles(aw_dly);
                s_axi_awaddr  = a;
                s_axi_awvalid = 1'b1;
                hs = 1'b0;
                for (n = 0; n < TMO && !hs; n++) begin
                    @(negedge clk);
                    hs = s_axi_awready;
                    @(posedge clk);
                    #1;
                end
                if (!hs) fail_now("aw_timeout");
                s_axi_awvalid = 1'b0;
            end
            begin
                bit hs;
                int n;
                wait_cycles(w_dly);
                s_axi_wdata  = d;
                s_axi_wvalid = 1'b1;
                hs = 1'b0;
                for (n = 0; n < TMO && !hs; n++) begin
                    @(negedge clk);
                    hs = s_axi_wready;
                    @(posedge clk);
                    #1;
                end
                if (!hs) fail_now("w_timeout");
                s_axi_wvalid = 1'b0;
            end
        join
        begin
            bit hs;
            int n;
            wait_cycles(b_dly);
            s_axi_bready = 1'b1;
            hs = 1'b0;
            for (n = 0; n < TMO && !hs; n++) begin
                @(negedge clk);
                hs = s_axi_bvalid;
                @(posedge clk);
                #1;
            end
            if (!hs) fail_now("b_timeout");
            s_axi_bready = 1'b0;
        end
    endtask

    task automatic read_drv(input logic [31:0] a, input int ar_dly, input int r_dly);
        bit hs;
        int n;
        wait_cycles(ar_dly);
        s_axi_araddr  = a;
        s_axi_arvalid = 1'b1;
        hs = 1'b0;
        for (n = 0; n < TMO && !hs; n++) begin
            @(negedge clk);
            hs = s_axi_arready;
            @(posedge clk);
            #1;
        end
        if (!hs) fail_now("ar_timeout");
        s_axi_arvalid = 1'b0;
        wait_cycles(r_dly);
        s_axi_rready = 1'b1;
        hs = 1'b0;
        for (n = 0; n < TMO && !hs; n++) begin
            @(negedge clk);
            hs = s_axi_rvalid;
            @(posedge clk);
            #1;
        end
        if (!hs) fail_now("r_timeout");
        s_axi_rready = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input int aw_dly, input int w_dly, input int b_dly);
        exp_b_q.push_back(model_wresp(a));
        write_drv(a, d, aw_dly, w_dly, b_dly);
        model_write(a, d);
    endtask

    task automatic do_read(input logic [31:0] a, input int ar_dly, input int r_dly);
        exp_r_q.push_back(model_read(a));
        read_drv(a, ar_dly, r_dly);
    endtask

    // ------------------------------------------------------ monitor
    logic       prev_bvalid, prev_bready, prev_rvalid, prev_rready;

    always @(negedge clk) begin
        if (!resetn) begin
            prev_bvalid = 1'b0;
            prev_bready = 1'b0;
            prev_rvalid = 1'b0;
            prev_rready = 1'b0;
        end else begin
            if (prev_bvalid && !prev_bready) check("bvalid_hold", s_axi_bvalid, 1'b1);
            if (prev_rvalid && !prev_rready) check("rvalid_hold", s_axi_rvalid, 1'b1);
            if (s_axi_bvalid) begin
                check("awready_in_resp", s_axi_awready, 1'b0);
                check("wready_in_resp", s_axi_wready, 1'b0);
                if (exp_b_q.size() == 0) begin
                    fail_now("b_unexpected");
                end else begin
                    check("bresp", s_axi_bresp, exp_b_q[0]);
                    if (s_axi_bready) void'(exp_b_q.pop_front());
                end
            end
            if (s_axi_rvalid) begin
                check("arready_in_data", s_axi_arready, 1'b0);
                if (exp_r_q.size() == 0) begin
                    fail_now("r_unexpected");
                end else begin
                    check("rdata", s_axi_rdata, exp_r_q[0][31:0]);
                    check("rresp", s_axi_rresp, exp_r_q[0][33:32]);
                    if (s_axi_rready) void'(exp_r_q.pop_front());
                end
            end
            prev_bvalid = s_axi_bvalid;
            prev_bready = s_axi_bready;
            prev_rvalid = s_axi_rvalid;
            prev_rready = s_axi_rready;
        end
    end

    // ------------------------------------------------------ stimulus
    task automatic check_idle_outputs(input string tag);
        check({tag, "_bvalid"},  s_axi_bvalid,  1'b0);
        check({tag, "_rvalid"},  s_axi_rvalid,  1'b0);
        check({tag, "_bresp"},   s_axi_bresp,   2'b00);
        check({tag, "_rresp"},   s_axi_rresp,   2'b00);
        check({tag, "_rdata"},   s_axi_rdata,   32'h0);
        check({tag, "_awready"}, s_axi_awready, 1'b0);
        check({tag, "_wready"},  s_axi_wready,  1'b0);
        check({tag, "_arready"}, s_axi_arready, 1'b0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic [33:0] old;
        bit          hs;

        resetn        = 1'b0;
        s_axi_awaddr  = '0;
        s_axi_awvalid = 1'b0;
        s_axi_wdata   = '0;
        s_axi_wvalid  = 1'b0;
        s_axi_bready  = 1'b0;
        s_axi_araddr  = '0;
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b0;
        model_clear();

        #12;
        check_idle_outputs("reset");
        @(posedge clk);
        #1;
        resetn = 1'b1;

        // Reset values and first writes
        check("lit_read0_reset", model_read(32'h00), {OKAY, 32'h0});
        do_read(32'h00, 0, 0);
        check("lit_wresp_00", model_wresp(32'h00), OKAY);
        do_write(32'h00, 32'hDEAD_BEEF, 0, 0, 0);
        check("lit_read_00", model_read(32'h00), {OKAY, 32'hDEAD_BEEF});
        do_read(32'h00, 0, 0);

        do_read(32'h20, 0, 0);
        do_write(32'h20, 32'hADAD_ABAB, 0, 0, 0);
        check("lit_read_20", model_read(32'h20), {OKAY, 32'hADAD_ABAB});
        do_read(32'h20, 0, 0);
        do_read(32'h00, 0, 2);

        // AW before W, then W before AW, each with bready stalled
        do_write(32'h10, 32'h1111_2222, 0, 3, 4);
        do_write(32'h14, 32'h3333_4444, 3, 0, 4);
        check("lit_read_10", model_read(32'h10), {OKAY, 32'h1111_2222});
        do_read(32'h10, 0, 3);
        do_read(32'h14, 1, 0);

        // Unmapped address: SLVERR both ways, nothing changes
        check("lit_wresp_40", model_wresp(32'h40), SLVERR);
        check("lit_read_40", model_read(32'h40), {SLVERR, 32'h0});
        do_write(32'h40, 32'hFFFF_FFFF, 0, 0, 1);
        do_read(32'h40, 0, 1);
        do_write(32'h8000_0004, 32'h1234_5678, 1, 1, 0);
        for (int i = 0; i < NUM_REGS; i++) do_read(32'(i * 4), 0, 0);

        // Low address bits ignored
        do_read(32'h23, 0, 0);
        do_write(32'h07, 32'h0707_0707, 0, 0, 0);
        check("lit_read_04", model_read(32'h04), {OKAY, 32'h0707_0707});
        do_read(32'h04, 0, 0);

        // Same-cycle write and read of one register: read sees the old value
        old = model_read(32'h00);
        check("lit_old_00", old, {OKAY, 32'hDEAD_BEEF});
        exp_b_q.push_back(model_wresp(32'h00));
        exp_r_q.push_back(old);
        fork
            write_drv(32'h00, 32'hCAFE_F00D, 0, 0, 0);
            read_drv(32'h00, 0, 0);
        join
        model_write(32'h00, 32'hCAFE_F00D);
        do_read(32'h00, 0, 0);

        // Top register (version register when the feature is built in)
        do_write(32'h3C, 32'h5A5A_5A5A, 0, 0, 0);
        do_read(32'h3C, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 9) < 8) begin
                a = {26'h0, 4'($urandom_range(0, NUM_REGS - 1)), 2'($urandom_range(0, 3))};
            end else if ($urandom_range(0, 1) == 1) begin
                a = 32'h40 + 32'($urandom_range(0, 255));
            end else begin
                a = $urandom() | 32'h1000_0000;
            end
            d = $urandom();
            if ($urandom_range(0, 1) == 1) begin
                do_write(a, d, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            end else begin
                do_read(a, $urandom_range(0, 2), $urandom_range(0, 3));
            end
        end

        // Asynchronous reset while a read response is stalled
        do_write(32'h00, 32'h1234_5678, 0, 0, 0);
        exp_r_q.push_back(model_read(32'h00));
        s_axi_araddr  = 32'h00;
        s_axi_arvalid = 1'b1;
        hs = 1'b0;
        for (int n = 0; n < TMO && !hs; n++) begin
            @(negedge clk);
            hs = s_axi_arready;
            @(posedge clk);
            #1;
        end
        if (!hs) fail_now("ar_timeout_rst");
        s_axi_arvalid = 1'b0;
        wait_cycles(2);
        check("rvalid_before_rst", s_axi_rvalid, 1'b1);
        @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check_idle_outputs("async_rst");
        exp_r_q.delete();
        exp_b_q.delete();
        model_clear();
        #20;
        @(negedge clk);
        #2;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        check("lit_read0_after_rst", model_read(32'h00), {OKAY, 32'h0});
        do_read(32'h00, 0, 0);
        do_read(32'h20, 0, 0);

        wait_cycles(3);
        check("b_queue_drained", exp_b_q.size(), 0);
        check("r_queue_drained", exp_r_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_lite_sub_regs.md
Name: axi_lite_sub_regs

Overview:
- AXI4-Lite subordinate holding a bank of 32-bit read/write registers. Sits behind an AXI4-Lite manager such as a bus VIP or interconnect port.
- Single outstanding read and single outstanding write; the two channels run concurrently.
- Responds OKAY for mapped addresses and SLVERR for unmapped addresses.

Parameters:
- ADDR_W, 32, width of s_axi_awaddr and s_axi_araddr
- DATA_W, 32, register and data-bus width (fixed at 32)
- NUM_REGS, 16, number of word registers; mapped range is 0x00 to NUM_REGS*4-4

Ports:
- clk  in  1  sole clock; everything is sampled on the rising edge
- resetn  in  1  asynchronous active-low reset
- s_axi_awaddr  in  ADDR_W  write address
- s_axi_awvalid  in  1  write address valid
- s_axi_awready  out  1  write address ready
- s_axi_wdata  in  DATA_W  write data
- s_axi_wvalid  in  1  write data valid
- s_axi_wready  out  1  write data ready
- s_axi_bresp  out  2  write response
- s_axi_bvalid  out  1  write response valid
- s_axi_bready  in  1  write response ready
- s_axi_araddr  in  ADDR_W  read address
- s_axi_arvalid  in  1  read address valid
- s_axi_arready  out  1  read address ready
- s_axi_rdata  out  DATA_W  read data
- s_axi_rresp  out  2  read response
- s_axi_rvalid  out  1  read data valid
- s_axi_rready  in  1  read data ready

Behaviour:
- Reset is asynchronous and active-low. While resetn=0:
  - all registers are 0;
  - bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0;
  - awready=0, wready=0, arready=0.
  - Any in-flight transaction is discarded.
- Decode: register index = addr[5:2] for NUM_REGS=16 (generally addr[$clog2(NUM_REGS)+1:2]).
  - addr[1:0] is ignored.
  - An address is mapped when addr < NUM_REGS*4; otherwise it is unmapped.
- Write path, states W_IDLE then W_RESP:
  - In W_IDLE, awready=1 until AW is captured and wready=1 until W is captured; AW and W are captured independently in either order or in the same cycle.
  - The cycle both are held (or arrive together), the register is written for a mapped address. bvalid rises on the next edge with bresp=OKAY(00), or SLVERR(10) for an unmapped address; an unmapped write changes no register. State goes to W_RESP.
  - W_RESP holds bvalid and bresp stable until bvalid&&bready, with awready=wready=0.
  - Minimum latency is one cycle from the AW+W handshake to bvalid.
- Read path, states R_IDLE then R_DATA:
  - In R_IDLE, arready=1. On arvalid&&arready, rdata and rresp are registered and rvalid=1 on the next edge.
  - Mapped address: rdata = register value, rresp=OKAY. Unmapped address: rdata=0, rresp=SLVERR.
  - R_DATA holds rdata, rresp and rvalid stable until rready, with arready=0; it then returns to R_IDLE.
- Simultaneous read and write to the same register in the same cycle: the read returns the old value (write-after-read ordering).
- Outputs never change while valid is high and ready is low.
- Back-to-back transactions: a new AR or AW/W is accepted no earlier than the cycle after the previous response handshake.

Optional Feature:
- Macro: AXI_SUB_VERSION_REG_EN.
- Defined:
  - register index NUM_REGS-1 (0x3C) is read-only and returns constant 32'h0001_0000;
  - writes to 0x3C are ignored and answered with SLVERR.
- Undefined: 0x3C is an ordinary read/write register.

Decomposition:
- Package axi_sub_pkg holds:
  - resp codes RESP_OKAY=2'b00 and RESP_SLVERR=2'b10;
  - VERSION_VAL;
  - the state enums for the write and read FSMs.
- One sub-module, axi_sub_regfile: register array with a write port (en, idx, data) and an asynchronous read port. The top level contains the two handshake FSMs and the decode logic.

Test Plan:
- Release reset, then read 0x00 -> rdata=0x00000000, rresp=OKAY.
- Write 0x00=0xDEADBEEF -> bresp=OKAY; read 0x00 -> 0xDEADBEEF.
- Read 0x20 -> 0x00000000; write 0x20=0xADADABAB -> OKAY; read 0x20 -> 0xADADABAB; read 0x00 -> still 0xDEADBEEF.
- Present AW 3 cycles before W (then W before AW), with bready held low 4 cycles -> exactly one write; bvalid and bresp stable until bready.
- Write and read 0x40 -> bresp=SLVERR, rresp=SLVERR, rdata=0; all registers unchanged.
- Assert resetn low while rvalid=1 and rready=0 -> rvalid drops immediately (asynchronously); after release, reading 0x00 returns 0.
